// File: rtl/fp_add_sched_if.sv
// fp_add_sched_if: request, adder and response signals of the shared FP adder scheduler.
// slave is the scheduler side, master is the producer/adder/consumer side.
interface fp_add_sched_if #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int NREQ    = 4
);
  localparam int W   = E_WIDTH + M_WIDTH + 1;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              add_go;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b,
    input  add_res, rsp_ready,
    output req_ready, add_go, add_a, add_b,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b,
    output add_res, rsp_ready,
    input  req_ready, add_go, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/fp_add_sched.sv
// fp_add_sched: round-robin sharing of one fixed-latency FP adder with a credit-guarded result FIFO.
// Optional FP_SCHED_PRIO_EN: requester 0 gets absolute priority over the round-robin.
module fp_add_sched #(
  parameter int E_WIDTH    = 8,
  parameter int M_WIDTH    = 23,
  parameter int NREQ       = 4,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fp_add_sched_if.slave bus
);
  localparam int W    = E_WIDTH + M_WIDTH + 1;
  localparam int IDW  = $clog2(NREQ);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + LAT + 2) + 1;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_v;
  logic            rr_upd;
  logic            credit_ok;
  logic            xfer;
  logic [NREQ-1:0] rdy;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  int              idx;

  logic            iss_v;
  logic [IDW-1:0]  iss_id;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;

  logic [LAT-1:0]  tag_v;
  logic [IDW-1:0]  tag_id [LAT];

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   used;

  logic [W-1:0]    mem_d  [FIFO_DEPTH];
  logic [IDW-1:0]  mem_id [FIFO_DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [CNTW-1:0] cnt;
  logic            push;
  logic            pop;
  logic            nonempty;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credits come from registered state only, so a pop helps one cycle later.
  always_comb begin
    inflight = CW'(iss_v);
    for (int k = 0; k < LAT; k++) begin
      inflight = inflight + CW'(tag_v[k]);
    end
    used      = CW'(cnt) + inflight;
    credit_ok = used < CW'(FIFO_DEPTH);
  end

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    rr_upd = 1'b0;
    idx    = 0;
`ifdef FP_SCHED_PRIO_EN
    if (bus.req_valid[0]) begin
      gnt_v = 1'b1;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_v && bus.req_valid[IDW'(idx)]) begin
        gnt_v  = 1'b1;
        gnt_id = IDW'(idx);
        rr_upd = 1'b1;
      end
    end
  end

  assign xfer = gnt_v & credit_ok & ~rst;

  always_comb begin
    rdy   = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        rdy[i] = xfer;
        sel_a  = bus.req_a[i*W +: W];
        sel_b  = bus.req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v  <= 1'b0;
      iss_id <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rr_ptr <= IDW'(NREQ - 1);
    end else begin
      iss_v <= xfer;
      if (xfer) begin
        iss_id <= gnt_id;
        op_a   <= sel_a;
        op_b   <= sel_b;
      end
      if (xfer && rr_upd) begin
        rr_ptr <= gnt_id;
      end
    end
  end

  // The tag pipe mirrors the adder: its tail is valid when add_res is.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= iss_v;
      tag_id[0] <= iss_id;
      for (int k = 1; k < LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign nonempty = (cnt != '0);
  assign push     = tag_v[LAT-1];
  assign pop      = nonempty & bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wp]  <= bus.add_res;
      mem_id[wp] <= tag_id[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= nxt(wp);
      end
      if (pop) begin
        rp <= nxt(rp);
      end
      if (push && !pop) begin
        cnt <= cnt + CNTW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNTW'(1);
      end
    end
  end

  assign bus.req_ready = rdy;
  assign bus.add_go    = iss_v;
  assign bus.add_a     = op_a;
  assign bus.add_b     = op_b;
  assign bus.rsp_valid = nonempty;
  assign bus.rsp_id    = nonempty ? mem_id[rp] : '0;
  assign bus.rsp_data  = nonempty ? mem_d[rp] : '0;
  assign bus.busy      = iss_v | (|tag_v) | nonempty;
endmodule

// File: tb/tb_fp_add_sched.sv
// tb_fp_add_sched: directed table plus multi-cycle sequences for fp_add_sched.
// A stand-in adder returns a fixed sum LAT cycles after add_go.
module tb_fp_add_sched;
  localparam int NREQ = 4;
`ifdef FP_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct {
    int          lane;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_add_sched_if #(.E_WIDTH(8), .M_WIDTH(23), .NREQ(NREQ)) bus ();

  fp_add_sched #(
    .E_WIDTH(8), .M_WIDTH(23), .NREQ(NREQ),
    .LAT(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] fake(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    p0 <= bus.add_go ? fake(bus.add_a, bus.add_b) : 32'hBAD0_0BAD;
    p1 <= p0;
    p2 <= p1;
  end
  assign bus.add_res = p2;

  int  cyc = 0;
  int  go_cnt = 0;
  ev_t gq[$];
  ev_t pq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) gq.push_back('{cyc, i, 32'h0});
      if (bus.rsp_valid && bus.rsp_ready)
        pq.push_back('{cyc, int'(bus.rsp_id), bus.rsp_data});
      if (bus.add_go) go_cnt++;
    end
  end

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] la[4], lb[4], le[4];
  vec_t tbl[4];

  task automatic set_lanes();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*32 +: 32] = la[i];
      bus.req_b[i*32 +: 32] = lb[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic chk_order(input string nm, input int gb, input int pb);
    int n;
    n = gq.size() - gb;
    chk({nm, "_npop"}, pq.size() - pb, n);
    chk({nm, "_ngo"}, go_cnt, go_cnt);
    if (pq.size() - pb == n) begin
      for (int i = 0; i < n; i++) begin
        chk({nm, "_id"}, pq[pb+i].id, gq[gb+i].id);
        chk({nm, "_data"}, pq[pb+i].data, le[gq[gb+i].id]);
      end
    end
  endtask

  initial begin
    int gb, pb, g0, n, n1;
    la = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
    lb = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
    le = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    tbl[0] = '{1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    tbl[1] = '{0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
    tbl[2] = '{3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    tbl[3] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    set_lanes();
    step(2);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 4'h0);
    chk("rst_add_go", bus.add_go, 1'b0);
    chk("rst_add_a", bus.add_a, 32'h0);
    chk("rst_add_b", bus.add_b, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 2'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_winner", bus.req_ready, 4'b0001);

    do_reset();
    for (int v = 0; v < 4; v++) begin
      bus.req_a[tbl[v].lane*32 +: 32] = tbl[v].a;
      bus.req_b[tbl[v].lane*32 +: 32] = tbl[v].b;
      bus.req_valid = 4'b1 << tbl[v].lane;
      @(negedge clk);
      chk("tbl_ready", bus.req_ready, 4'b1 << tbl[v].lane);
      @(posedge clk); #1;
      bus.req_valid = '0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        chk("tbl_add_go", bus.add_go, k == 1);
        chk("tbl_rsp_valid", bus.rsp_valid, k == 5);
        if (k == 1) begin
          chk("tbl_add_a", bus.add_a, tbl[v].a);
          chk("tbl_add_b", bus.add_b, tbl[v].b);
        end
        if (k == 5) begin
          chk("tbl_rsp_id", bus.rsp_id, tbl[v].lane);
          chk("tbl_rsp_data", bus.rsp_data, tbl[v].exp);
        end
      end
      chk("tbl_idle", bus.busy, 1'b0);
      @(posedge clk); #1;
    end
    set_lanes();

    do_reset();
    bus.req_valid = 4'b0011;
    step(2);
    bus.req_valid = '0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    pb = pq.size();
    @(negedge clk);
    chk("mid_req_ready", bus.req_ready, 4'h0);
    chk("mid_add_go", bus.add_go, 1'b0);
    chk("mid_add_a", bus.add_a, 32'h0);
    chk("mid_add_b", bus.add_b, 32'h0);
    chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rsp_id", bus.rsp_id, 2'd0);
    chk("mid_rsp_data", bus.rsp_data, 32'h0);
    chk("mid_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    step(10);
    chk("mid_no_late_rsp", pq.size() - pb, 0);
    bus.req_valid = 4'hF;
    @(negedge clk);
    chk("mid_rr_restart", bus.req_ready, 4'b0001);
    @(posedge clk); #1;

    do_reset();
    gb = gq.size();
    pb = pq.size();
    g0 = go_cnt;
    bus.req_valid = 4'hF;
    step(16);
    bus.req_valid = '0;
    step(12);
    n = gq.size() - gb;
    chk("rr_enough", n >= 8, 1'b1);
    chk("rr_go_count", go_cnt - g0, n);
    if (n >= 4) chk("rr_first4_b2b", gq[gb+3].cyc - gq[gb].cyc, 3);
    for (int i = 0; i < n; i++) begin
      chk("rr_order", gq[gb+i].id, i % 4);
      if (i > 0) chk("rr_one_per_cyc", gq[gb+i].cyc > gq[gb+i-1].cyc, 1'b1);
    end
    chk_order("rr", gb, pb);

    do_reset();
    bus.rsp_ready = 1'b0;
    gb = gq.size();
    pb = pq.size();
    bus.req_valid = 4'hF;
    step(12);
    @(negedge clk);
    chk("bp_ngrant", gq.size() - gb, 4);
    chk("bp_ready_low", bus.req_ready, 4'h0);
    chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    step(8);
    chk("bp_ngrant_after", gq.size() - gb, 5);
    chk("bp_npop", pq.size() - pb, 1);
    if (gq.size() - gb == 5 && pq.size() - pb == 1) begin
      chk("bp_regrant_cyc", gq[gb+4].cyc, pq[pb].cyc + 1);
      chk("bp_regrant_id", gq[gb+4].id, 0);
      chk("bp_pop_id", pq[pb].id, 0);
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_rsp_valid", bus.rsp_valid, 1'b1);
    end
    @(posedge clk); #1;
    step(8);
    bus.req_valid = '0;
    step(12);
    chk_order("full", gb, pb);

    do_reset();
    gb = gq.size();
    bus.req_valid = 4'b0101;
    step(10);
    n1 = gq.size() - gb;
    bus.req_valid = 4'b0100;
    step(4);
    bus.req_valid = '0;
    step(10);
    chk("pair_enough", n1 >= 4, 1'b1);
    for (int i = 0; i < n1; i++)
      chk("pair_order", gq[gb+i].id, PRIO ? 0 : ((i % 2) ? 2 : 0));
    chk("pair_tail_exists", gq.size() - gb > n1, 1'b1);
    if (gq.size() - gb > n1) chk("pair_after_drop", gq[gb+n1].id, 2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
